conv_encoder_framer: RTL and testbench

- Rate-1/2, constraint-length-4 (8-state) convolutional encoder and framer that feeds the Viterbi decoder's `d_in[1:0]` and `enable` inputs.
- Accepts an information bitstream with a valid/ready handshake. Encodes each bit into a 2-bit symbol.
- At the end of each frame, appends K-1 = 3 zero tail bits so the trellis returns to state 000. The decoder therefore starts every frame from validity = state 0.
- Presents symbols through a registered valid/ready output stage and drives a frame-active `enable` level for the decoder.

---
 rtl/viterbi_pkg.sv | 31 +++
 rtl/conv_enc_core.sv | 32 +++
 rtl/conv_encoder_framer.sv | 223 ++++++++++++++++++++++
 tb/tb_conv_encoder_framer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the rate-1/2, K=4 convolutional encoder feeding the Viterbi decoder.
package viterbi_pkg;

  localparam int K        = 4;
  localparam int NSTATES  = 8;
  localparam int TAIL_LEN = 3;

  localparam logic [3:0] G0_DEFAULT = 4'b1111;
  localparam logic [3:0] G1_DEFAULT = 4'b1101;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_t;

  // Observation bundle for checkers: FSM state, trellis state and tail progress.
  typedef struct packed {
    enc_state_t state;
    logic [2:0] sreg;
    logic [1:0] tail_cnt;
  } enc_dbg_t;

  // Generator tap order is {current bit, 1-old, 2-old, 3-old}; s[0] is the newest past bit.
  function automatic logic tap_parity(input logic [3:0] g, input logic b, input logic [2:0] s);
    return ^(g & {b, s[0], s[1], s[2]});
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational rate-1/2 encoder over a 3-bit trellis shift register with load and clear.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter logic [3:0] G0 = G0_DEFAULT,
  parameter logic [3:0] G1 = G1_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_bit,
  input  logic       i_load,
  input  logic       i_clear,
  output sym_t       o_sym,
  output logic [2:0] o_state
);

  logic [2:0] r_sreg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sreg <= 3'b000;
    end else if (i_clear) begin
      r_sreg <= 3'b000;
    end else if (i_load) begin
      r_sreg <= {r_sreg[1:0], i_bit};
    end
  end

  assign o_sym   = {tap_parity(G1, i_bit, r_sreg), tap_parity(G0, i_bit, r_sreg)};
  assign o_state = r_sreg;

endmodule

// File: rtl/conv_encoder_framer.sv
// Convolutional encoder + zero-tail framer with a register/skid output stage and decoder enable.
// Symbol error injection ports are added when CONV_ENC_ERR_INJECT_EN is defined.
module conv_encoder_framer
  import viterbi_pkg::*;
#(
  parameter logic [3:0] G0        = G0_DEFAULT,
  parameter logic [3:0] G1        = G1_DEFAULT,
  parameter int         MAX_FRAME = 1024,
  parameter int         CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             in_ready,
  output logic             sym_valid,
  output sym_t             sym_o,
  input  logic             sym_ready,
  output logic             enc_enable,
  output logic             frame_err,
`ifdef CONV_ENC_ERR_INJECT_EN
  input  logic             inj_en,
  input  logic [CNT_W+1:0] inj_idx,
  input  sym_t             inj_mask,
`endif
  output enc_dbg_t         o_dbg
);

  // Valid/ready: a transfer happens on a posedge where valid and ready are both high; a raised
  // valid holds with stable data until it transfers. in_ready is registered from buffer occupancy.

  // One extra counter bit so the MAX_FRAME compare can never wrap.
  localparam logic [CNT_W:0] MAX_CNT      = MAX_FRAME[CNT_W:0];
  localparam logic [1:0]     TAIL_CNT_END = 2'(TAIL_LEN);
  localparam logic [1:0]     TAIL_CNT_LST = 2'(TAIL_LEN - 1);

  enc_state_t     r_state;
  enc_state_t     w_state_next;
  logic [CNT_W:0] r_cnt;
  logic [CNT_W:0] w_cnt_inc;
  logic [1:0]     r_tail_cnt;
  logic           r_in_ready;
  logic           r_enc_en;
  logic           r_frame_err;
  logic           w_err_set;

  logic           r_out_v;
  logic           r_out_last;
  sym_t           r_out_d;
  logic           r_skid_v;
  logic           r_skid_last;
  sym_t           r_skid_d;
  logic           w_out_v_n;
  logic           w_out_last_n;
  sym_t           w_out_d_n;
  logic           w_skid_v_n;
  logic           w_skid_last_n;
  sym_t           w_skid_d_n;

  logic           w_acc;
  logic           w_tail_push;
  logic           w_push;
  logic           w_push_last;
  logic           w_pop;
  logic           w_frame_done;
  logic           w_hit_max;
  logic           w_enc_bit;
  sym_t           w_enc_sym;
  sym_t           w_push_sym;
  logic [2:0]     w_sreg;

  assign w_acc        = in_valid && r_in_ready;
  assign w_tail_push  = (r_state == TAIL) && (r_tail_cnt != TAIL_CNT_END) && !r_skid_v;
  assign w_push       = w_acc || w_tail_push;
  assign w_push_last  = w_tail_push && (r_tail_cnt == TAIL_CNT_LST);
  assign w_pop        = r_out_v && sym_ready;
  assign w_frame_done = w_pop && r_out_last;
  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_hit_max    = (w_cnt_inc == MAX_CNT);
  assign w_enc_bit    = w_acc ? in_bit : 1'b0;

  conv_enc_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_bit   (w_enc_bit),
    .i_load  (w_push),
    .i_clear (w_frame_done),
    .o_sym   (w_enc_sym),
    .o_state (w_sreg)
  );

`ifdef CONV_ENC_ERR_INJECT_EN
  // Index of the next pushed symbol within the frame, data and tail alike.
  logic [CNT_W+1:0] r_sym_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sym_idx <= '0;
    end else if (w_push) begin
      r_sym_idx <= w_push_last ? '0 : r_sym_idx + 1'b1;
    end
  end

  assign w_push_sym = (inj_en && (r_sym_idx == inj_idx)) ? (w_enc_sym ^ inj_mask) : w_enc_sym;
`else
  assign w_push_sym = w_enc_sym;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_err_set    = 1'b0;
    unique case (r_state)
      IDLE, DATA: begin
        if (w_acc) begin
          if (in_last) begin
            w_state_next = TAIL;
          end else if (w_hit_max) begin
            w_state_next = TAIL;
            w_err_set    = 1'b1;
          end else begin
            w_state_next = DATA;
          end
        end
      end
      TAIL: begin
        if (w_frame_done) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The skid entry only fills when the output register is held or is refilling from the skid.
  always_comb begin
    w_out_v_n     = r_out_v;
    w_out_d_n     = r_out_d;
    w_out_last_n  = r_out_last;
    w_skid_v_n    = r_skid_v;
    w_skid_d_n    = r_skid_d;
    w_skid_last_n = r_skid_last;
    if (!r_out_v || w_pop) begin
      if (r_skid_v) begin
        w_out_v_n    = 1'b1;
        w_out_d_n    = r_skid_d;
        w_out_last_n = r_skid_last;
      end else begin
        w_out_v_n    = w_push;
        w_out_d_n    = w_push ? w_push_sym : r_out_d;
        w_out_last_n = w_push && w_push_last;
      end
      w_skid_v_n = 1'b0;
    end
    if (w_push && r_out_v && (!w_pop || r_skid_v)) begin
      w_skid_v_n    = 1'b1;
      w_skid_d_n    = w_push_sym;
      w_skid_last_n = w_push_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_v     <= 1'b0;
      r_out_d     <= 2'b00;
      r_out_last  <= 1'b0;
      r_skid_v    <= 1'b0;
      r_skid_d    <= 2'b00;
      r_skid_last <= 1'b0;
      r_in_ready  <= 1'b0;
      r_enc_en    <= 1'b0;
      r_frame_err <= 1'b0;
      r_cnt       <= '0;
      r_tail_cnt  <= 2'd0;
    end else begin
      r_out_v     <= w_out_v_n;
      r_out_d     <= w_out_d_n;
      r_out_last  <= w_out_last_n;
      r_skid_v    <= w_skid_v_n;
      r_skid_d    <= w_skid_d_n;
      r_skid_last <= w_skid_last_n;
      r_in_ready  <= (w_state_next != TAIL) && !w_skid_v_n;
      r_frame_err <= w_err_set;
      if (w_frame_done) begin
        r_enc_en <= 1'b0;
      end else if (w_out_v_n) begin
        r_enc_en <= 1'b1;
      end
      if (w_frame_done) begin
        r_cnt <= '0;
      end else if (w_acc) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_frame_done) begin
        r_tail_cnt <= 2'd0;
      end else if (w_tail_push) begin
        r_tail_cnt <= r_tail_cnt + 2'd1;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign sym_valid  = r_out_v;
  assign sym_o      = r_out_d;
  assign enc_enable = r_enc_en;
  assign frame_err  = r_frame_err;

  assign o_dbg.state    = r_state;
  assign o_dbg.sreg     = w_sreg;
  assign o_dbg.tail_cnt = r_tail_cnt;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Scoreboard bench for conv_encoder_framer (MAX_FRAME=16); injection test runs when CONV_ENC_ERR_INJECT_EN is defined.
module tb_conv_encoder_framer;
  import viterbi_pkg::*;

  localparam int MAXF = 16;
  localparam int CW   = 4;

  logic     clk;
  logic     rst;
  logic     in_valid;
  logic     in_bit;
  logic     in_last;
  logic     in_ready;
  logic     sym_valid;
  sym_t     sym_o;
  logic     sym_ready;
  logic     enc_enable;
  logic     frame_err;
  enc_dbg_t dbg;
`ifdef CONV_ENC_ERR_INJECT_EN
  logic          inj_en;
  logic [CW+1:0] inj_idx;
  sym_t          inj_mask;
`endif

  conv_encoder_framer #(
    .MAX_FRAME (MAXF),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .sym_valid  (sym_valid),
    .sym_o      (sym_o),
    .sym_ready  (sym_ready),
    .enc_enable (enc_enable),
    .frame_err  (frame_err),
`ifdef CONV_ENC_ERR_INJECT_EN
    .inj_en     (inj_en),
    .inj_idx    (inj_idx),
    .inj_mask   (inj_mask),
`endif
    .o_dbg      (dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [1:0] exp_q[$];
  logic       h1, h2, h3;
  int         m_cnt;
  int         m_idx;
  int         exp_err;
  logic       m_inj_en;
  int         m_inj_idx;
  logic [1:0] m_inj_mask;

  task automatic model_reset();
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    m_cnt = 0;
    m_idx = 0;
    exp_q.delete();
  endtask

  // G0=1111 -> b^h1^h2^h3, G1=1101 -> b^h1^h3; h1 is the 1-cycle-old bit.
  task automatic model_push(input logic b);
    logic [1:0] s;
    s = {b ^ h1 ^ h3, b ^ h1 ^ h2 ^ h3};
    if (m_inj_en && (m_idx == m_inj_idx)) s = s ^ m_inj_mask;
    m_idx++;
    exp_q.push_back(s);
    h3 = h2; h2 = h1; h1 = b;
  endtask

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b, input logic last);
    int waited;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1'b1);
    end else begin
      model_push(b);
      m_cnt++;
      if (last || m_cnt == MAXF) begin
        if (!last) exp_err++;
        for (int t = 0; t < TAIL_LEN; t++) model_push(1'b0);
        m_cnt = 0;
        m_idx = 0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || enc_enable) && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_idle"}, dbg.state, IDLE);
    check({tag, "_sreg"}, dbg.sreg, 3'b000);
  endtask

  // ---------------- monitor ----------------
  logic bp_en;
  int   err_seen;
  int   pops;
  int   last_en_len;

  initial begin : monitor
    logic bp_pat[0:5];
    int   bp_idx;
    int   en_len;
    logic prev_stall;
    sym_t prev_sym;
    logic [1:0] e;
    bp_pat[0] = 1'b1; bp_pat[1] = 1'b0; bp_pat[2] = 1'b0;
    bp_pat[3] = 1'b1; bp_pat[4] = 1'b0; bp_pat[5] = 1'b1;
    bp_idx = 0; en_len = 0; prev_stall = 1'b0; prev_sym = 2'b00;
    sym_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
        en_len     = 0;
      end else begin
        if (bp_en) begin
          sym_ready = bp_pat[bp_idx % 6];
          bp_idx++;
        end else begin
          sym_ready = 1'b1;
        end
        if (prev_stall) begin
          check("hold_valid", sym_valid, 1'b1);
          check("hold_data", sym_o, prev_sym);
        end
        if (frame_err) err_seen++;
        if (enc_enable) begin
          en_len++;
        end else if (en_len != 0) begin
          last_en_len = en_len;
          en_len      = 0;
        end
        if (sym_valid && sym_ready) begin
          pops++;
          check("enable_with_sym", enc_enable, 1'b1);
          check("sym_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sym", sym_o, e);
          end
        end
        prev_stall = sym_valid && !sym_ready;
        prev_sym   = sym_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic frame16[0:15];
  logic frame8[0:7];
  int   p0;

  initial begin
    n_vec = 0; n_err = 0; exp_err = 0; err_seen = 0; pops = 0; last_en_len = 0;
    bp_en = 1'b0;
    m_inj_en = 1'b0; m_inj_idx = 0; m_inj_mask = 2'b00;
`ifdef CONV_ENC_ERR_INJECT_EN
    inj_en = 1'b0; inj_idx = '0; inj_mask = 2'b00;
`endif
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    model_reset();

    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_sym_valid", sym_valid, 1'b0);
    check("rst_sym_o", sym_o, 2'b00);
    check("rst_enable", enc_enable, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_state", dbg.state, IDLE);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single-bit frame: 11, 11, 01, 11
    send_bit(1'b1, 1'b1);
    check("first_latency", sym_valid, 1'b1);
    drain("single");
    check("single_enable_len", last_en_len, 4);

    // 8-bit frame
    frame8[0] = 1; frame8[1] = 0; frame8[2] = 1; frame8[3] = 1;
    frame8[4] = 0; frame8[5] = 0; frame8[6] = 0; frame8[7] = 0;
    p0 = pops;
    for (int i = 0; i < 8; i++) send_bit(frame8[i], i == 7);
    drain("frame8");
    check("frame8_count", pops - p0, 11);

    // 16-bit frame ending exactly at MAX_FRAME with in_last, then the same bits under backpressure
    for (int i = 0; i < 16; i++) frame16[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 16; i++) send_bit(frame16[i], i == 15);
    drain("frame16");
    check("max_with_last_no_err", err_seen, 0);
    bp_en = 1'b1;
    p0 = pops;
    for (int i = 0; i < 16; i++) send_bit(frame16[i], i == 15);
    drain("frame16_bp");
    bp_en = 1'b0;
    check("frame16_bp_count", pops - p0, 19);

    // Overlong: 20 bits without in_last, then a closing bit
    p0 = pops;
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    send_bit(1'b1, 1'b1);
    drain("overlong");
    check("overlong_err", err_seen, 1);
    check("overlong_count", pops - p0, 27);

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_sym_valid", sym_valid, 1'b0);
    check("midrst_sym_o", sym_o, 2'b00);
    check("midrst_enable", enc_enable, 1'b0);
    check("midrst_state", dbg.state, IDLE);
    check("midrst_sreg", dbg.sreg, 3'b000);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send_bit(1'b1, 1'b1);
    drain("after_rst");

`ifdef CONV_ENC_ERR_INJECT_EN
    // Injection on symbol 2 of a single-bit frame: 11, 11, 00, 11
    inj_en = 1'b1; inj_idx = 6'd2; inj_mask = 2'b01;
    m_inj_en = 1'b1; m_inj_idx = 2; m_inj_mask = 2'b01;
    send_bit(1'b1, 1'b1);
    drain("inject");
    inj_en = 1'b0; m_inj_en = 1'b0;
`endif

    check("frame_err_total", err_seen, exp_err);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
